fir_spi_tx: RTL and testbench

FIR_SPI_TX -- requirements
Module: fir_spi_tx

---
 rtl/fir_spi_tx.sv | 118 +++++++++++
 tb/tb_fir_spi_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_spi_tx.sv
// SPI mode-0 transmitter serialising one signed sample per frame, MSB first.
// Define FIR_SPI_TX_PARITY_EN to append an even-parity bit after the LSB.
module fir_spi_tx #(
   parameter int unsigned NUM_BITS = 16,
   parameter int unsigned CLK_DIV  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tx_valid,
   input  logic signed [NUM_BITS-1:0] tx_data,
   output logic                       tx_ready,
   output logic                       sclk,
   output logic                       mosi,
   output logic                       cs_n,
   output logic                       busy,
   output logic                       done
);

`ifdef FIR_SPI_TX_PARITY_EN
   localparam int unsigned FRAME_BITS = NUM_BITS + 1;
`else
   localparam int unsigned FRAME_BITS = NUM_BITS;
`endif
   localparam int unsigned BW = $clog2(FRAME_BITS + 1);
   localparam logic [7:0]    HALF_LAST = 8'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, DONE} state_t;

   state_t                state, state_nxt;
   logic [7:0]            half_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic [FRAME_BITS-1:0] load_val;
   logic                  armed;
   logic                  half_end;
   logic                  last_bit;
   logic                  accept;

   assign half_end = (half_cnt == HALF_LAST);
   assign last_bit = (bit_cnt == BIT_LAST);
   assign accept   = tx_ready && tx_valid;

   always_comb begin
`ifdef FIR_SPI_TX_PARITY_EN
      load_val = {tx_data, ^tx_data};
`else
      load_val = tx_data;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_ready  = 1'b0;
      sclk      = 1'b0;
      mosi      = 1'b0;
      cs_n      = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            // held low until the first edge after reset release
            tx_ready = armed;
            if (tx_valid && armed) state_nxt = SHIFT_LO;
         end
         SHIFT_LO: begin
            cs_n = 1'b0;
            busy = 1'b1;
            mosi = shreg[FRAME_BITS-1];
            if (half_end) state_nxt = SHIFT_HI;
         end
         SHIFT_HI: begin
            cs_n = 1'b0;
            busy = 1'b1;
            sclk = 1'b1;
            mosi = shreg[FRAME_BITS-1];
            if (half_end) state_nxt = last_bit ? HOLD : SHIFT_LO;
         end
         HOLD: begin
            cs_n = 1'b0;
            busy = 1'b1;
            if (half_end) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed    <= 1'b0;
         half_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         armed <= 1'b1;
         if (state_nxt != state || state == IDLE || state == DONE) half_cnt <= '0;
         else                                                       half_cnt <= half_cnt + 8'd1;
         if (accept) begin
            shreg   <= load_val;
            bit_cnt <= '0;
         end else if (state == SHIFT_HI && half_end) begin
            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fir_spi_tx.sv
// Directed bench for fir_spi_tx (NUM_BITS=16, CLK_DIV=2); samples at negedge+1.
module tb_fir_spi_tx;

`ifdef FIR_SPI_TX_PARITY_EN
   localparam int FB = 17;
`else
   localparam int FB = 16;
`endif
   localparam int CS_LOW = 2 * 2 * FB + 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               tx_valid = 1'b0;
   logic signed [15:0] tx_data = '0;
   logic               tx_ready, sclk, mosi, cs_n, busy, done;

   int checks = 0;
   int errors = 0;

   fir_spi_tx #(.NUM_BITS(16), .CLK_DIV(2)) dut (
      .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic [31:0] rx_bits = '0;
   int          rx_n = 0;
   int          rise_q[$];
   int          cs_low = 0;
   int          done_cnt = 0;
   int          cs_fall_cyc = 0;
   logic        prev_sclk = 1'b0;
   logic        prev_cs = 1'b1;

   always @(negedge clk) begin
      if (sclk && !prev_sclk) begin
         rx_bits = {rx_bits[30:0], mosi};
         rx_n++;
         rise_q.push_back(cyc);
      end
      prev_sclk = sclk;
      if (!cs_n) cs_low++;
      if (!cs_n && prev_cs) cs_fall_cyc = cyc;
      prev_cs = cs_n;
      if (done) done_cnt++;
   end

   function automatic logic [31:0] frame_of(input logic [15:0] d);
`ifdef FIR_SPI_TX_PARITY_EN
      return {15'd0, d, ^d};
`else
      return {16'd0, d};
`endif
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clr_mon();
      rx_bits = '0;
      rx_n = 0;
      rise_q.delete();
      cs_low = 0;
      done_cnt = 0;
      cs_fall_cyc = 0;
   endtask

   task automatic pulse(input logic [15:0] d);
      tx_valid = 1'b1;
      tx_data = d;
      tick();
      tx_valid = 1'b0;
      tx_data = 16'h5A5A;
   endtask

   task automatic wait_done(output bit ok, output int at);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (done === 1'b1) begin
            ok = 1'b1;
            at = cyc;
            return;
         end
      end
   endtask

   task automatic test_reset();
      tick();
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", tx_ready); end
      checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got %b exp 1", cs_n); end
      checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b exp 0", sclk); end
      checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b exp 0", mosi); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
      reset = 1'b0;
      #1;
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_pre got %b exp 0", tx_ready); end
      tick();
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", tx_ready); end
   endtask

   task automatic test_8001();
      bit ok;
      int at;
      clr_mon();
      pulse(16'h8001);
      wait_done(ok, at);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL f8001_timeout got %b exp 1", ok); end
      checks++; if (rx_bits !== frame_of(16'h8001)) begin errors++; $display("FAIL f8001_bits got %h exp %h", rx_bits, frame_of(16'h8001)); end
      checks++; if (rx_n !== FB) begin errors++; $display("FAIL f8001_nbits got %0d exp %0d", rx_n, FB); end
      checks++; if (cs_n !== 1'b1 || mosi !== 1'b0 || sclk !== 1'b0) begin errors++; $display("FAIL f8001_done_pins got cs_n=%b mosi=%b sclk=%b exp 1 0 0", cs_n, mosi, sclk); end
      tick();
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL f8001_ready_after got %b exp 1", tx_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL f8001_done_width got %b exp 0", done); end
      checks++; if (cs_low !== CS_LOW) begin errors++; $display("FAIL f8001_cs_low got %0d exp %0d", cs_low, CS_LOW); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL f8001_done_cnt got %0d exp 1", done_cnt); end
   endtask

   task automatic test_a5c3();
      bit ok;
      int at;
      int bad;
      clr_mon();
      pulse(16'hA5C3);
      wait_done(ok, at);
      tick();
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL a5c3_timeout got %b exp 1", ok); end
      checks++; if (rx_bits !== frame_of(16'hA5C3)) begin errors++; $display("FAIL a5c3_bits got %h exp %h", rx_bits, frame_of(16'hA5C3)); end
      checks++; if (rise_q.size() !== FB) begin errors++; $display("FAIL a5c3_rises got %0d exp %0d", rise_q.size(), FB); end
      bad = 0;
      for (int j = 1; j < rise_q.size(); j++)
         if (rise_q[j] - rise_q[j-1] != 4) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL a5c3_spacing got %0d bad gaps exp 0", bad); end
   endtask

   task automatic test_8000();
      bit ok;
      int at;
      logic exp_last;
`ifdef FIR_SPI_TX_PARITY_EN
      exp_last = 1'b1;
`else
      exp_last = 1'b0;
`endif
      clr_mon();
      pulse(16'h8000);
      wait_done(ok, at);
      tick();
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL f8000_timeout got %b exp 1", ok); end
      checks++; if (rx_bits !== frame_of(16'h8000)) begin errors++; $display("FAIL f8000_bits got %h exp %h", rx_bits, frame_of(16'h8000)); end
      checks++; if (rx_bits[0] !== exp_last) begin errors++; $display("FAIL f8000_last_bit got %b exp %b", rx_bits[0], exp_last); end
      checks++; if (cs_low !== CS_LOW) begin errors++; $display("FAIL f8000_cs_low got %0d exp %0d", cs_low, CS_LOW); end
   endtask

   task automatic test_ignore_busy();
      bit ok;
      int at;
      clr_mon();
      pulse(16'h00FF);
      repeat (10) tick();
      checks++; if (tx_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ign_busy got ready=%b busy=%b exp 0 1", tx_ready, busy); end
      tx_valid = 1'b1;
      tx_data = 16'h1234;
      tick();
      tx_valid = 1'b0;
      wait_done(ok, at);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ign_timeout got %b exp 1", ok); end
      checks++; if (rx_bits !== frame_of(16'h00FF)) begin errors++; $display("FAIL ign_bits got %h exp %h", rx_bits, frame_of(16'h00FF)); end
      repeat (20) tick();
      checks++; if (done_cnt !== 1 || rx_n !== FB) begin errors++; $display("FAIL ign_queued got done=%0d bits=%0d exp 1 %0d", done_cnt, rx_n, FB); end
      checks++; if (cs_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ign_idle got cs_n=%b busy=%b exp 1 0", cs_n, busy); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit found;
      int at;
      clr_mon();
      pulse(16'hFFFF);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (rx_n == 4 && sclk === 1'b0 && cs_n === 1'b0) found = 1'b1;
      end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_reach_bit5 got %b exp 1", found); end
      reset = 1'b1;
      #1;
      checks++; if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_pins got cs_n=%b sclk=%b busy=%b exp 1 0 0", cs_n, sclk, busy); end
      checks++; if (tx_ready !== 1'b0 || mosi !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_outs got ready=%b mosi=%b done=%b exp 0 0 0", tx_ready, mosi, done); end
      tick();
      reset = 1'b0;
      tick();
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", tx_ready); end
      clr_mon();
      repeat (5) tick();
      checks++; if (cs_low !== 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_no_resume got cs_low=%0d busy=%b exp 0 0", cs_low, busy); end
      pulse(16'h0F0F);
      wait_done(ok, at);
      tick();
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_new_timeout got %b exp 1", ok); end
      checks++; if (rx_bits !== frame_of(16'h0F0F)) begin errors++; $display("FAIL mid_new_bits got %h exp %h", rx_bits, frame_of(16'h0F0F)); end
      checks++; if (cs_low !== CS_LOW) begin errors++; $display("FAIL mid_new_cs_low got %0d exp %0d", cs_low, CS_LOW); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int d1;
      int at;
      logic [31:0] mask;
      logic [31:0] got;
      mask = (32'd1 << FB) - 32'd1;
      clr_mon();
      tx_valid = 1'b1;
      tx_data = 16'h9669;
      tick();
      tx_data = 16'h3C5A;
      wait_done(ok, d1);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_first_timeout got %b exp 1", ok); end
      cs_fall_cyc = 0;
      tick();
      tick();
      tx_valid = 1'b0;
      checks++; if (cs_fall_cyc - d1 !== 2) begin errors++; $display("FAIL b2b_gap got %0d exp 2", cs_fall_cyc - d1); end
      wait_done(ok, at);
      tick();
      got = rx_bits & mask;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_second_timeout got %b exp 1", ok); end
      checks++; if (got !== frame_of(16'h3C5A)) begin errors++; $display("FAIL b2b_bits got %h exp %h", got, frame_of(16'h3C5A)); end
      checks++; if (rx_n !== 2 * FB || done_cnt !== 2) begin errors++; $display("FAIL b2b_counts got bits=%0d done=%0d exp %0d 2", rx_n, done_cnt, 2 * FB); end
   endtask

   initial begin
      test_reset();
      test_8001();
      test_a5c3();
      test_8000();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
